// File: rtl/matrix_pkg.sv
// Shared types and helpers for the result display path: segment byte type,
// blank pattern, hex glyph lookup and the viewer FSM states.
package matrix_pkg;

    typedef logic [7:0] seg7_t;

    localparam seg7_t SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        SHOW
    } display_state_e;

    // Active-low segments, bit 7 = dp (kept off), bits 6..0 = g..a.
    function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a single-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            if (sync_b != level) begin
                if (cnt == CNT_LAST) begin
                    // Pulse only on the 0 -> 1 flip, aligned with the level change.
                    level <= ~level;
                    cnt   <= '0;
                    pulse <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/result_hex_viewer.sv
// Reads the completed result matrix one element at a time and shows it on four
// 7-segment digits; steps on a debounced button press or on an auto-scroll timer.
module result_hex_viewer
    import matrix_pkg::*;
#(
    parameter int N               = 4,
    parameter int DW              = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_CYCLES     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     result_valid,
    output logic [$clog2(N*N)-1:0]   rd_addr,
    output logic                     rd_en,
    input  logic [DW-1:0]            rd_data,
    input  logic                     step_btn,
    input  logic                     sw_mode,
    output logic [3:0][7:0]          hexDisplays,
    output logic [$clog2(N*N)-1:0]   elem_idx,
    output logic                     showing
);

    localparam int AW  = $clog2(N*N);
    localparam int ACW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [AW-1:0]  IDX_LAST  = AW'(N*N - 1);
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_CYCLES - 1);

    display_state_e state;
    display_state_e state_next;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_next;
    logic [ACW-1:0] auto_cnt;
    logic           auto_tick;
    logic           step_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .pulse(step_pulse)
    );

    assign auto_tick = (state == SHOW) && sw_mode && (auto_cnt == AUTO_LAST);
    assign rd_en     = (state == FETCH);
    assign rd_addr   = idx;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE:  ;
            FETCH: state_next = WAIT;
            WAIT:  state_next = SHOW;
            SHOW: begin
                if ((step_pulse && !sw_mode) || auto_tick) begin
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new result matrix always restarts from element 0, overriding any step.
        if (result_valid) begin
            state_next = FETCH;
            idx_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            elem_idx    <= '0;
            showing     <= 1'b0;
            auto_cnt    <= '0;
            hexDisplays <= {4{SEG_BLANK}};
        end else begin
            state <= state_next;
            idx   <= idx_next;

            if (state == WAIT && !result_valid) begin
                for (int d = 0; d < 4; d++) begin
                    hexDisplays[d] <= hex_to_seg7(rd_data[4*d +: 4]);
                end
                elem_idx <= idx;
                showing  <= 1'b1;
            end

            if (state == SHOW && sw_mode && !auto_tick) begin
                auto_cnt <= auto_cnt + 1'b1;
            end else begin
                auto_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_result_hex_viewer.sv
// Self-checking bench for result_hex_viewer: small RAM model, glyph table and
// an element-index model drive expectations for each scenario.
module tb_result_hex_viewer;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int DC = 4;
    localparam int AC = 8;
    localparam int AW = $clog2(N*N);

    logic           clk = 1'b0;
    logic           rst;
    logic           result_valid;
    logic [AW-1:0]  rd_addr;
    logic           rd_en;
    logic [DW-1:0]  rd_data;
    logic           step_btn;
    logic           sw_mode;
    logic [3:0][7:0] hexDisplays;
    logic [AW-1:0]  elem_idx;
    logic           showing;

    int total = 0;
    int bad   = 0;
    int model_idx = 0;

    logic [15:0] mem [0:N*N-1];

    // Lit segments (active-high), bit order {g,f,e,d,c,b,a}.
    logic [6:0] lit [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    result_hex_viewer #(
        .N(N), .DW(DW), .DEBOUNCE_CYCLES(DC), .AUTO_CYCLES(AC)
    ) dut (
        .clk(clk), .rst(rst), .result_valid(result_valid),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .step_btn(step_btn), .sw_mode(sw_mode),
        .hexDisplays(hexDisplays), .elem_idx(elem_idx), .showing(showing)
    );

    function automatic logic [31:0] exp_disp(input logic [15:0] w);
        logic [31:0] r;
        for (int d = 0; d < 4; d++) r[8*d +: 8] = {1'b1, ~lit[w[4*d +: 4]]};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hi, input int lo);
        step_btn = 1'b1;
        repeat (hi) cyc();
        step_btn = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic pulse_valid();
        result_valid = 1'b1;
        cyc();
        result_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit seen_rd;
        rst = 1'b1; result_valid = 1'b0; step_btn = 1'b0; sw_mode = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        seen_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (rd_en) seen_rd = 1'b1;
        end
        total++; if (hexDisplays !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_disp: got %h want ffffffff", hexDisplays); end
        total++; if (showing !== 1'b0) begin bad++; $display("FAIL reset_showing: got %b want 0", showing); end
        total++; if (elem_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", elem_idx); end
        total++; if (rd_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        total++; if (seen_rd !== 1'b0) begin bad++; $display("FAIL idle_rd_en: got %b want 0", seen_rd); end
    endtask

    task automatic test_load();
        result_valid = 1'b1;
        cyc();
        result_valid = 1'b0;
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL load_rd_en: got %b want 1", rd_en); end
        total++; if (rd_addr !== '0) begin bad++; $display("FAIL load_rd_addr: got %0d want 0", rd_addr); end
        cyc();
        total++; if (hexDisplays !== 32'hFFFFFFFF) begin bad++; $display("FAIL load_early: got %h want ffffffff", hexDisplays); end
        cyc();
        model_idx = 0;
        total++; if (hexDisplays !== exp_disp(mem[0])) begin bad++; $display("FAIL load_disp: got %h want %h", hexDisplays, exp_disp(mem[0])); end
        total++; if (elem_idx !== AW'(0)) begin bad++; $display("FAIL load_idx: got %0d want 0", elem_idx); end
        total++; if (showing !== 1'b1) begin bad++; $display("FAIL load_showing: got %b want 1", showing); end
    endtask

    task automatic test_manual();
        for (int k = 0; k < 4; k++) begin
            press(10, 10);
            model_idx = (model_idx + 1) % (N*N);
            total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL manual_idx: got %0d want %0d", elem_idx, model_idx); end
            total++; if (hexDisplays !== exp_disp(mem[model_idx])) begin bad++; $display("FAIL manual_disp: got %h want %h", hexDisplays, exp_disp(mem[model_idx])); end
            total++; if (showing !== 1'b1) begin bad++; $display("FAIL manual_showing: got %b want 1", showing); end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            step_btn = (i % 2 == 0);
            repeat (2) cyc();
        end
        step_btn = 1'b1;
        repeat (20) cyc();
        model_idx = (model_idx + 1) % (N*N);
        total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL bounce_idx: got %0d want %0d", elem_idx, model_idx); end
        repeat (80) cyc();
        total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL held_idx: got %0d want %0d", elem_idx, model_idx); end
        total++; if (hexDisplays !== exp_disp(mem[model_idx])) begin bad++; $display("FAIL held_disp: got %h want %h", hexDisplays, exp_disp(mem[model_idx])); end
        step_btn = 1'b0;
        repeat (20) cyc();
    endtask

    task automatic test_auto();
        logic [AW-1:0] prev;
        int n;
        pulse_valid();
        repeat (2) cyc();
        model_idx = 0;
        total++; if (elem_idx !== AW'(0)) begin bad++; $display("FAIL auto_start_idx: got %0d want 0", elem_idx); end
        sw_mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            prev = elem_idx;
            n = 0;
            while (elem_idx === prev && n < 20) begin
                if (n == 0 && k == 2) step_btn = 1'b1;
                if (n == 0 && k == 3) step_btn = 1'b0;
                cyc();
                n++;
            end
            model_idx = (model_idx + 1) % (N*N);
            total++; if (n !== 10) begin bad++; $display("FAIL auto_period: got %0d want 10", n); end
            total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL auto_idx: got %0d want %0d", elem_idx, model_idx); end
            total++; if (hexDisplays !== exp_disp(mem[model_idx])) begin bad++; $display("FAIL auto_disp: got %h want %h", hexDisplays, exp_disp(mem[model_idx])); end
        end
        sw_mode = 1'b0;
        repeat (15) cyc();
        total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL auto_off_idx: got %0d want %0d", elem_idx, model_idx); end
    endtask

    task automatic test_priority();
        bit saw_next;
        press(10, 10);
        press(10, 10);
        model_idx = (model_idx + 2) % (N*N);
        total++; if (elem_idx !== AW'(2)) begin bad++; $display("FAIL prio_setup_idx: got %0d want 2", elem_idx); end
        step_btn = 1'b1;
        repeat (6) cyc();
        result_valid = 1'b1;
        cyc();
        result_valid = 1'b0;
        saw_next = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (elem_idx === AW'(3)) saw_next = 1'b1;
        end
        step_btn = 1'b0;
        repeat (10) cyc();
        model_idx = 0;
        total++; if (saw_next !== 1'b0) begin bad++; $display("FAIL prio_step_taken: got %b want 0", saw_next); end
        total++; if (elem_idx !== AW'(0)) begin bad++; $display("FAIL prio_idx: got %0d want 0", elem_idx); end
        total++; if (hexDisplays !== exp_disp(mem[0])) begin bad++; $display("FAIL prio_disp: got %h want %h", hexDisplays, exp_disp(mem[0])); end
        total++; if (showing !== 1'b1) begin bad++; $display("FAIL prio_showing: got %b want 1", showing); end
    endtask

    task automatic test_reset_in_wait();
        pulse_valid();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (hexDisplays !== 32'hFFFFFFFF) begin bad++; $display("FAIL rstwait_disp: got %h want ffffffff", hexDisplays); end
        total++; if (showing !== 1'b0) begin bad++; $display("FAIL rstwait_showing: got %b want 0", showing); end
        total++; if (elem_idx !== '0) begin bad++; $display("FAIL rstwait_idx: got %0d want 0", elem_idx); end
        repeat (5) cyc();
        total++; if (hexDisplays !== 32'hFFFFFFFF) begin bad++; $display("FAIL rstwait_idle_disp: got %h want ffffffff", hexDisplays); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL rstwait_rd_en: got %b want 0", rd_en); end
    endtask

    task automatic test_random();
        for (int i = 0; i < N*N; i++) mem[i] = 16'($urandom);
        pulse_valid();
        repeat (2) cyc();
        model_idx = 0;
        total++; if (hexDisplays !== exp_disp(mem[0])) begin bad++; $display("FAIL rand_load_disp: got %h want %h", hexDisplays, exp_disp(mem[0])); end
        for (int k = 0; k < 6; k++) begin
            press(10 + $urandom_range(0, 10), 8 + $urandom_range(0, 12));
            model_idx = (model_idx + 1) % (N*N);
            total++; if (elem_idx !== AW'(model_idx)) begin bad++; $display("FAIL rand_idx: got %0d want %0d", elem_idx, model_idx); end
            total++; if (hexDisplays !== exp_disp(mem[model_idx])) begin bad++; $display("FAIL rand_disp: got %h want %h", hexDisplays, exp_disp(mem[model_idx])); end
        end
    endtask

    initial begin
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        mem[2] = 16'h0F00;
        mem[3] = 16'hFFFF;
        test_reset();
        test_load();
        test_manual();
        test_bounce();
        test_auto();
        test_priority();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
